// File: rtl/eth_ctrl_pkg.sv
// eth_ctrl_pkg
// Shared definitions for the 10G port control block: the per-channel
// FSM state encoding, statistics counter select codes and link speed codes.
// No ports; imported by eth_ch_ctrl and eth_port_ctrl.
package eth_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_DOWN = 2'd1,
    S_UP   = 2'd2
  } ch_state_t;

  // Counter select codes; the same index is used for the event vector bit
  // order inside each channel.
  localparam logic [2:0] SEL_TX_OK  = 3'd0;
  localparam logic [2:0] SEL_TX_ERR = 3'd1;
  localparam logic [2:0] SEL_RX_OK  = 3'd2;
  localparam logic [2:0] SEL_RX_ERR = 3'd3;
  localparam logic [2:0] SEL_RX_CRC = 3'd4;
  localparam int         NUM_STATS  = 5;

  localparam logic [3:0] SPEED_NONE = 4'h0;
  localparam logic [3:0] SPEED_10G  = 4'h1;

endpackage

// File: rtl/eth_ch_ctrl.sv
// eth_ch_ctrl
// One channel of the port controller: reset stretcher, link debounce FSM,
// configuration shadow registers and five saturating event counters.
// Ports:
//   sys_clk, sys_rst_n        clock, async active-low reset
//   soft_rst                  software reset request (level)
//   block_lock                PCS block lock
//   ev[4:0]                   event pulses, bit order = counter select code
//   cfg_we + cfg_*            shadow write strobe and new values
//   clr_en, clr_sel           clear one counter (read-with-clear)
//   ch_rst                    core reset, polarity set by RST_ACTIVE_HIGH
//   local_mac..promiscuous    shadow outputs
//   link_up, link_speed       debounced link state
//   stat_cnt                  all five counters, index = select code
module eth_ch_ctrl
  import eth_ctrl_pkg::*;
#(
  parameter int          RST_STRETCH        = 16,
  parameter int          LINK_UP_CYCLES     = 1024,
  parameter int          STAT_WIDTH         = 32,
  parameter int          RST_ACTIVE_HIGH    = 0,
  parameter logic [47:0] LOCAL_MAC          = 48'hAABBCCDDEEFF,
  parameter logic [47:0] DEFAULT_DEST_MAC   = 48'h001122334455,
  parameter logic [15:0] DEFAULT_ETHER_TYPE = 16'h0800
) (
  input  logic                                 sys_clk,
  input  logic                                 sys_rst_n,
  input  logic                                 soft_rst,
  input  logic                                 block_lock,
  input  logic [NUM_STATS-1:0]                 ev,
  input  logic                                 cfg_we,
  input  logic [47:0]                          cfg_local_mac,
  input  logic [47:0]                          cfg_dest_mac,
  input  logic [15:0]                          cfg_ether_type,
  input  logic                                 cfg_promiscuous,
  input  logic                                 clr_en,
  input  logic [2:0]                           clr_sel,
  output logic                                 ch_rst,
  output logic [47:0]                          local_mac,
  output logic [47:0]                          dest_mac,
  output logic [15:0]                          ether_type,
  output logic                                 promiscuous,
  output logic                                 link_up,
  output logic [3:0]                           link_speed,
  output logic [NUM_STATS-1:0][STAT_WIDTH-1:0] stat_cnt
);

  localparam int SW = $clog2(RST_STRETCH);
  localparam int DW = (LINK_UP_CYCLES > 1) ? $clog2(LINK_UP_CYCLES) : 1;
  localparam logic [SW-1:0] STRETCH_LAST = SW'(RST_STRETCH - 1);
  localparam logic [DW-1:0] DEB_LAST     = DW'(LINK_UP_CYCLES - 1);
  localparam logic          RST_ON       = (RST_ACTIVE_HIGH != 0);

  ch_state_t            state;
  logic [SW-1:0]        stretch_cnt;
  logic [DW-1:0]        deb_cnt;
  logic [NUM_STATS-1:0] ev_live;

  // The stretch counter counts edges with every reset source released, so
  // the release happens on the RST_STRETCH-th such edge. Loss of lock drops
  // the link immediately; only the rising direction is debounced.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_RST;
      stretch_cnt <= '0;
      deb_cnt     <= '0;
      ch_rst      <= RST_ON;
      link_up     <= 1'b0;
      link_speed  <= SPEED_NONE;
    end else if (soft_rst) begin
      state       <= S_RST;
      stretch_cnt <= '0;
      deb_cnt     <= '0;
      ch_rst      <= RST_ON;
      link_up     <= 1'b0;
      link_speed  <= SPEED_NONE;
    end else begin
      unique case (state)
        S_RST: begin
          if (stretch_cnt == STRETCH_LAST) begin
            state       <= S_DOWN;
            stretch_cnt <= '0;
            ch_rst      <= ~RST_ON;
          end else begin
            stretch_cnt <= stretch_cnt + 1'b1;
          end
        end
        S_DOWN: begin
          if (!block_lock) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state      <= S_UP;
            deb_cnt    <= '0;
            link_up    <= 1'b1;
            link_speed <= SPEED_10G;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        S_UP: begin
          if (!block_lock) begin
            state      <= S_DOWN;
            link_up    <= 1'b0;
            link_speed <= SPEED_NONE;
          end
        end
        default: begin
          state       <= S_RST;
          stretch_cnt <= '0;
          deb_cnt     <= '0;
          ch_rst      <= RST_ON;
          link_up     <= 1'b0;
          link_speed  <= SPEED_NONE;
        end
      endcase
    end
  end

  // Shadows only reset with sys_rst_n so configuration survives soft reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      local_mac   <= LOCAL_MAC;
      dest_mac    <= DEFAULT_DEST_MAC;
      ether_type  <= DEFAULT_ETHER_TYPE;
      promiscuous <= 1'b0;
    end else if (cfg_we) begin
      local_mac   <= cfg_local_mac;
      dest_mac    <= cfg_dest_mac;
      ether_type  <= cfg_ether_type;
      promiscuous <= cfg_promiscuous;
    end
  end

  assign ev_live = ev & {NUM_STATS{state != S_RST}};

  // A clear coinciding with an event leaves 1 so that event is not lost.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stat_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_STATS; k++) begin
        if (clr_en && (clr_sel == 3'(k))) begin
          stat_cnt[k] <= ev_live[k] ? STAT_WIDTH'(1) : '0;
        end else if (ev_live[k] && (stat_cnt[k] != '1)) begin
          stat_cnt[k] <= stat_cnt[k] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eth_port_ctrl.sv
// eth_port_ctrl
// Multi-channel control/status block for the 10G MAC/PCS subsystem.
// Instantiates one eth_ch_ctrl per channel, decodes configuration writes
// and provides a registered statistics read port.
// Ports:
//   sys_clk, sys_rst_n                clock, async active-low reset
//   ch_soft_rst, rx_block_lock        per-channel reset request / lock
//   tx_/rx_frame_*, rx_crc_error      per-channel event pulses
//   config_*                          shadow write port
//   ch_rst, ch_local_mac .. link_speed per-channel outputs (channel i at slice i)
//   stat_rd_*                         read request / registered response
module eth_port_ctrl
  import eth_ctrl_pkg::*;
#(
  parameter int          NUM_CH             = 2,
  parameter int          CH_W               = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int          RST_STRETCH        = 16,
  parameter int          LINK_UP_CYCLES     = 1024,
  parameter int          STAT_WIDTH         = 32,
  parameter int          RST_ACTIVE_HIGH    = 0,
  parameter logic [47:0] LOCAL_MAC          = 48'hAABBCCDDEEFF,
  parameter logic [47:0] DEFAULT_DEST_MAC   = 48'h001122334455,
  parameter logic [15:0] DEFAULT_ETHER_TYPE = 16'h0800
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [NUM_CH-1:0]      ch_soft_rst,
  input  logic [NUM_CH-1:0]      rx_block_lock,
  input  logic [NUM_CH-1:0]      tx_frame_valid,
  input  logic [NUM_CH-1:0]      tx_frame_error,
  input  logic [NUM_CH-1:0]      rx_frame_valid,
  input  logic [NUM_CH-1:0]      rx_frame_error,
  input  logic [NUM_CH-1:0]      rx_crc_error,
  input  logic                   config_valid,
  input  logic [CH_W-1:0]        config_ch,
  input  logic [47:0]            config_local_mac,
  input  logic [47:0]            config_dest_mac,
  input  logic [15:0]            config_ether_type,
  input  logic                   config_promiscuous,
  output logic [NUM_CH-1:0]      ch_rst,
  output logic [48*NUM_CH-1:0]   ch_local_mac,
  output logic [48*NUM_CH-1:0]   ch_dest_mac,
  output logic [16*NUM_CH-1:0]   ch_ether_type,
  output logic [NUM_CH-1:0]      ch_promiscuous,
  output logic [NUM_CH-1:0]      link_up,
  output logic [4*NUM_CH-1:0]    link_speed,
  input  logic                   stat_rd_en,
  input  logic [CH_W-1:0]        stat_rd_ch,
  input  logic [2:0]             stat_rd_sel,
  input  logic                   stat_rd_clr,
  output logic [STAT_WIDTH-1:0]  stat_rd_data,
  output logic                   stat_rd_valid
);

  logic [NUM_STATS-1:0][STAT_WIDTH-1:0] ch_cnt [NUM_CH];
  logic [STAT_WIDTH-1:0]                rd_word;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range config_ch / stat_rd_ch values match no channel, so they
    // write and clear nothing.
    logic cfg_we;
    logic clr_en;
    assign cfg_we = config_valid && (config_ch == CH_W'(i));
    assign clr_en = stat_rd_en && stat_rd_clr && (stat_rd_ch == CH_W'(i));

    eth_ch_ctrl #(
      .RST_STRETCH       (RST_STRETCH),
      .LINK_UP_CYCLES    (LINK_UP_CYCLES),
      .STAT_WIDTH        (STAT_WIDTH),
      .RST_ACTIVE_HIGH   (RST_ACTIVE_HIGH),
      .LOCAL_MAC         (LOCAL_MAC),
      .DEFAULT_DEST_MAC  (DEFAULT_DEST_MAC),
      .DEFAULT_ETHER_TYPE(DEFAULT_ETHER_TYPE)
    ) u_ch (
      .sys_clk        (sys_clk),
      .sys_rst_n      (sys_rst_n),
      .soft_rst       (ch_soft_rst[i]),
      .block_lock     (rx_block_lock[i]),
      .ev             ({rx_crc_error[i], rx_frame_error[i], rx_frame_valid[i],
                        tx_frame_error[i], tx_frame_valid[i]}),
      .cfg_we         (cfg_we),
      .cfg_local_mac  (config_local_mac),
      .cfg_dest_mac   (config_dest_mac),
      .cfg_ether_type (config_ether_type),
      .cfg_promiscuous(config_promiscuous),
      .clr_en         (clr_en),
      .clr_sel        (stat_rd_sel),
      .ch_rst         (ch_rst[i]),
      .local_mac      (ch_local_mac[48*i +: 48]),
      .dest_mac       (ch_dest_mac[48*i +: 48]),
      .ether_type     (ch_ether_type[16*i +: 16]),
      .promiscuous    (ch_promiscuous[i]),
      .link_up        (link_up[i]),
      .link_speed     (link_speed[4*i +: 4]),
      .stat_cnt       (ch_cnt[i])
    );
  end

  // Reading via explicit matches keeps out-of-range ch/sel at zero without
  // indexing past the array bounds.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int k = 0; k < NUM_STATS; k++) begin
        if ((stat_rd_ch == CH_W'(i)) && (stat_rd_sel == 3'(k))) begin
          rd_word = ch_cnt[i][k];
        end
      end
    end
  end

  // The counter value sampled here is the pre-increment value of this edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stat_rd_valid <= 1'b0;
      stat_rd_data  <= '0;
    end else begin
      stat_rd_valid <= stat_rd_en;
      stat_rd_data  <= stat_rd_en ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_eth_port_ctrl.sv
// tb_eth_port_ctrl
// Directed, self-checking bench for eth_port_ctrl with NUM_CH=3 (so an
// out-of-range channel code exists), RST_STRETCH=16, LINK_UP_CYCLES=8,
// STAT_WIDTH=4, active-low ch_rst.
module tb_eth_port_ctrl;

  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;
  localparam int SW     = 4;

  logic                sys_clk;
  logic                sys_rst_n;
  logic [NUM_CH-1:0]   ch_soft_rst;
  logic [NUM_CH-1:0]   rx_block_lock;
  logic [NUM_CH-1:0]   tx_frame_valid;
  logic [NUM_CH-1:0]   tx_frame_error;
  logic [NUM_CH-1:0]   rx_frame_valid;
  logic [NUM_CH-1:0]   rx_frame_error;
  logic [NUM_CH-1:0]   rx_crc_error;
  logic                config_valid;
  logic [CH_W-1:0]     config_ch;
  logic [47:0]         config_local_mac;
  logic [47:0]         config_dest_mac;
  logic [15:0]         config_ether_type;
  logic                config_promiscuous;
  logic [NUM_CH-1:0]   ch_rst;
  logic [48*NUM_CH-1:0] ch_local_mac;
  logic [48*NUM_CH-1:0] ch_dest_mac;
  logic [16*NUM_CH-1:0] ch_ether_type;
  logic [NUM_CH-1:0]   ch_promiscuous;
  logic [NUM_CH-1:0]   link_up;
  logic [4*NUM_CH-1:0] link_speed;
  logic                stat_rd_en;
  logic [CH_W-1:0]     stat_rd_ch;
  logic [2:0]          stat_rd_sel;
  logic                stat_rd_clr;
  logic [SW-1:0]       stat_rd_data;
  logic                stat_rd_valid;

  int errors = 0;
  int checks = 0;

  eth_port_ctrl #(
    .NUM_CH        (NUM_CH),
    .RST_STRETCH   (16),
    .LINK_UP_CYCLES(8),
    .STAT_WIDTH    (SW),
    .RST_ACTIVE_HIGH(0)
  ) dut (
    .sys_clk           (sys_clk),
    .sys_rst_n         (sys_rst_n),
    .ch_soft_rst       (ch_soft_rst),
    .rx_block_lock     (rx_block_lock),
    .tx_frame_valid    (tx_frame_valid),
    .tx_frame_error    (tx_frame_error),
    .rx_frame_valid    (rx_frame_valid),
    .rx_frame_error    (rx_frame_error),
    .rx_crc_error      (rx_crc_error),
    .config_valid      (config_valid),
    .config_ch         (config_ch),
    .config_local_mac  (config_local_mac),
    .config_dest_mac   (config_dest_mac),
    .config_ether_type (config_ether_type),
    .config_promiscuous(config_promiscuous),
    .ch_rst            (ch_rst),
    .ch_local_mac      (ch_local_mac),
    .ch_dest_mac       (ch_dest_mac),
    .ch_ether_type     (ch_ether_type),
    .ch_promiscuous    (ch_promiscuous),
    .link_up           (link_up),
    .link_speed        (link_speed),
    .stat_rd_en        (stat_rd_en),
    .stat_rd_ch        (stat_rd_ch),
    .stat_rd_sel       (stat_rd_sel),
    .stat_rd_clr       (stat_rd_clr),
    .stat_rd_data      (stat_rd_data),
    .stat_rd_valid     (stat_rd_valid)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Issue one read request for a single edge and return the response.
  task automatic read_stat(input logic [CH_W-1:0] ch, input logic [2:0] sel,
                           input logic clr, output logic [SW-1:0] data,
                           output logic valid);
    stat_rd_en  = 1'b1;
    stat_rd_ch  = ch;
    stat_rd_sel = sel;
    stat_rd_clr = clr;
    tick();
    data  = stat_rd_data;
    valid = stat_rd_valid;
    stat_rd_en  = 1'b0;
    stat_rd_clr = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    tick(3);
    checks++;
    if (ch_rst !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_ch_rst: got %b expected %b", ch_rst, 3'b000);
    end
    checks++;
    if (link_up !== 3'b000 || link_speed !== 12'h000) begin
      errors++; $display("[TB] FAIL reset_link: got up=%b speed=%h expected 0/000", link_up, link_speed);
    end
    checks++;
    if (stat_rd_valid !== 1'b0 || stat_rd_data !== 4'h0) begin
      errors++; $display("[TB] FAIL reset_rd: got valid=%b data=%h expected 0/0", stat_rd_valid, stat_rd_data);
    end
    checks++;
    if (ch_local_mac !== {3{48'hAABBCCDDEEFF}} || ch_dest_mac !== {3{48'h001122334455}}
        || ch_ether_type !== {3{16'h0800}} || ch_promiscuous !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_shadows: got local=%h dest=%h type=%h prom=%b expected defaults",
                         ch_local_mac, ch_dest_mac, ch_ether_type, ch_promiscuous);
    end
    sys_rst_n = 1'b1;
    tick(15);
    checks++;
    if (ch_rst !== 3'b000) begin
      errors++; $display("[TB] FAIL stretch_edge15: got %b expected %b", ch_rst, 3'b000);
    end
    tick();
    checks++;
    if (ch_rst !== 3'b111) begin
      errors++; $display("[TB] FAIL stretch_edge16: got %b expected %b", ch_rst, 3'b111);
    end
    checks++;
    if (link_up !== 3'b000) begin
      errors++; $display("[TB] FAIL post_reset_link: got %b expected %b", link_up, 3'b000);
    end
  endtask

  task automatic test_config();
    config_valid       = 1'b1;
    config_ch          = 2'd1;
    config_local_mac   = 48'h111111111111;
    config_dest_mac    = 48'h0A0B0C0D0E0F;
    config_ether_type  = 16'h86DD;
    config_promiscuous = 1'b1;
    tick();
    config_valid = 1'b0;
    checks++;
    if (ch_dest_mac[95:48] !== 48'h0A0B0C0D0E0F || ch_local_mac[95:48] !== 48'h111111111111
        || ch_ether_type[31:16] !== 16'h86DD || ch_promiscuous !== 3'b010) begin
      errors++; $display("[TB] FAIL cfg_ch1: got dest=%h local=%h type=%h prom=%b expected 0a0b0c0d0e0f/111111111111/86dd/010",
                         ch_dest_mac[95:48], ch_local_mac[95:48], ch_ether_type[31:16], ch_promiscuous);
    end
    checks++;
    if (ch_dest_mac[47:0] !== 48'h001122334455 || ch_dest_mac[143:96] !== 48'h001122334455
        || ch_ether_type[15:0] !== 16'h0800 || ch_ether_type[47:32] !== 16'h0800) begin
      errors++; $display("[TB] FAIL cfg_others: got dest=%h type=%h expected defaults on ch0/ch2",
                         ch_dest_mac, ch_ether_type);
    end
    config_valid       = 1'b1;
    config_ch          = 2'd3;
    config_local_mac   = 48'h222222222222;
    config_dest_mac    = 48'h333333333333;
    config_ether_type  = 16'h88CC;
    config_promiscuous = 1'b1;
    tick();
    config_valid = 1'b0;
    tick();
    checks++;
    if (ch_dest_mac !== {48'h001122334455, 48'h0A0B0C0D0E0F, 48'h001122334455}
        || ch_ether_type !== {16'h0800, 16'h86DD, 16'h0800} || ch_promiscuous !== 3'b010) begin
      errors++; $display("[TB] FAIL cfg_out_of_range: got dest=%h type=%h prom=%b expected unchanged",
                         ch_dest_mac, ch_ether_type, ch_promiscuous);
    end
  endtask

  task automatic test_debounce();
    rx_block_lock = 3'b011;
    tick(7);
    rx_block_lock = 3'b000;
    tick();
    checks++;
    if (link_up !== 3'b000) begin
      errors++; $display("[TB] FAIL deb_short_run: got %b expected %b", link_up, 3'b000);
    end
    rx_block_lock = 3'b011;
    tick(7);
    checks++;
    if (link_up !== 3'b000) begin
      errors++; $display("[TB] FAIL deb_7_of_8: got %b expected %b", link_up, 3'b000);
    end
    tick();
    checks++;
    if (link_up !== 3'b011 || link_speed !== 12'h011) begin
      errors++; $display("[TB] FAIL deb_up: got up=%b speed=%h expected 011/011", link_up, link_speed);
    end
  endtask

  task automatic test_soft_reset();
    logic [SW-1:0] d;
    logic          v;
    tx_frame_valid = 3'b010;
    tick(3);
    tx_frame_valid = 3'b000;
    ch_soft_rst    = 3'b010;
    tick();
    checks++;
    if (ch_rst !== 3'b101 || link_up !== 3'b001 || link_speed !== 12'h001) begin
      errors++; $display("[TB] FAIL soft_assert: got rst=%b up=%b speed=%h expected 101/001/001",
                         ch_rst, link_up, link_speed);
    end
    rx_frame_valid = 3'b010;
    tick();
    rx_frame_valid = 3'b000;
    tick();
    ch_soft_rst = 3'b000;
    tick(15);
    checks++;
    if (ch_rst !== 3'b101) begin
      errors++; $display("[TB] FAIL soft_stretch15: got %b expected %b", ch_rst, 3'b101);
    end
    tick();
    checks++;
    if (ch_rst !== 3'b111) begin
      errors++; $display("[TB] FAIL soft_release: got %b expected %b", ch_rst, 3'b111);
    end
    checks++;
    if (ch_dest_mac[95:48] !== 48'h0A0B0C0D0E0F || link_up[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL soft_keep: got dest1=%h up0=%b expected 0a0b0c0d0e0f/1",
                         ch_dest_mac[95:48], link_up[0]);
    end
    read_stat(2'd1, 3'd0, 1'b0, d, v);
    checks++;
    if (d !== 4'd3 || v !== 1'b1) begin
      errors++; $display("[TB] FAIL soft_tx_ok_kept: got %h valid=%b expected 3/1", d, v);
    end
    read_stat(2'd1, 3'd2, 1'b0, d, v);
    checks++;
    if (d !== 4'd0 || v !== 1'b1) begin
      errors++; $display("[TB] FAIL soft_rx_ignored: got %h valid=%b expected 0/1", d, v);
    end
  endtask

  task automatic test_link_loss();
    rx_block_lock = 3'b010;
    tick();
    checks++;
    if (link_up[0] !== 1'b0 || link_speed[3:0] !== 4'h0) begin
      errors++; $display("[TB] FAIL loss: got up0=%b speed0=%h expected 0/0", link_up[0], link_speed[3:0]);
    end
  endtask

  task automatic test_stats();
    logic [SW-1:0] d;
    logic          v;
    rx_frame_valid = 3'b100;
    tick(20);
    rx_frame_valid = 3'b000;
    tx_frame_error = 3'b100;
    tick(2);
    tx_frame_error = 3'b000;
    rx_crc_error   = 3'b001;
    tick();
    rx_crc_error   = 3'b000;
    read_stat(2'd2, 3'd2, 1'b0, d, v);
    checks++;
    if (d !== 4'hF || v !== 1'b1) begin
      errors++; $display("[TB] FAIL sat_rx_ok: got %h valid=%b expected f/1", d, v);
    end
    read_stat(2'd2, 3'd1, 1'b0, d, v);
    checks++;
    if (d !== 4'h2) begin
      errors++; $display("[TB] FAIL tx_err_cnt: got %h expected 2", d);
    end
    read_stat(2'd0, 3'd4, 1'b0, d, v);
    checks++;
    if (d !== 4'h1) begin
      errors++; $display("[TB] FAIL crc_cnt: got %h expected 1", d);
    end
    rx_frame_valid = 3'b100;
    read_stat(2'd2, 3'd2, 1'b1, d, v);
    rx_frame_valid = 3'b000;
    checks++;
    if (d !== 4'hF || v !== 1'b1) begin
      errors++; $display("[TB] FAIL clr_with_event: got %h valid=%b expected f/1", d, v);
    end
    read_stat(2'd2, 3'd2, 1'b0, d, v);
    checks++;
    if (d !== 4'h1 || v !== 1'b1) begin
      errors++; $display("[TB] FAIL post_clear: got %h valid=%b expected 1/1", d, v);
    end
    tick();
    checks++;
    if (stat_rd_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL valid_one_cycle: got %b expected 0", stat_rd_valid);
    end
  endtask

  task automatic test_invalid_read();
    logic [SW-1:0] d;
    logic          v;
    read_stat(2'd2, 3'd7, 1'b1, d, v);
    checks++;
    if (d !== 4'h0 || v !== 1'b1) begin
      errors++; $display("[TB] FAIL bad_sel: got %h valid=%b expected 0/1", d, v);
    end
    read_stat(2'd3, 3'd1, 1'b1, d, v);
    checks++;
    if (d !== 4'h0 || v !== 1'b1) begin
      errors++; $display("[TB] FAIL bad_ch: got %h valid=%b expected 0/1", d, v);
    end
    read_stat(2'd2, 3'd2, 1'b0, d, v);
    checks++;
    if (d !== 4'h1) begin
      errors++; $display("[TB] FAIL bad_no_clear_rx: got %h expected 1", d);
    end
    read_stat(2'd2, 3'd1, 1'b0, d, v);
    checks++;
    if (d !== 4'h2) begin
      errors++; $display("[TB] FAIL bad_no_clear_txerr: got %h expected 2", d);
    end
  endtask

  initial begin
    sys_rst_n          = 1'b0;
    ch_soft_rst        = '0;
    rx_block_lock      = '0;
    tx_frame_valid     = '0;
    tx_frame_error     = '0;
    rx_frame_valid     = '0;
    rx_frame_error     = '0;
    rx_crc_error       = '0;
    config_valid       = 1'b0;
    config_ch          = '0;
    config_local_mac   = '0;
    config_dest_mac    = '0;
    config_ether_type  = '0;
    config_promiscuous = 1'b0;
    stat_rd_en         = 1'b0;
    stat_rd_ch         = '0;
    stat_rd_sel        = '0;
    stat_rd_clr        = 1'b0;
    test_reset();
    test_config();
    test_debounce();
    test_soft_reset();
    test_link_loss();
    test_stats();
    test_invalid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_port_ctrl.md
# eth_port_ctrl

Multi-channel control and status block for the 10G MAC/PCS subsystem, instantiated beside NUM_CH MAC+PCS channel pairs. Per channel it provides a stretched core reset with software reset, shadowed run-time configuration with parametrised defaults, a debounced link-state machine driving link_up/link_speed, and saturating frame-event statistics counters read through a single request/response port.

## Interface
- NUM_CH, 2: channel count, 1..8; CH_W = max(1, clog2(NUM_CH))
- RST_STRETCH, 16: cycles ch_rst stays active after a reset source releases, at least 2
- LINK_UP_CYCLES, 1024: consecutive rx_block_lock-high cycles required to declare link up
- STAT_WIDTH, 32: width of each statistics counter
- RST_ACTIVE_HIGH, 0: ch_rst polarity; 0 = active-low
- LOCAL_MAC, 48'hAABBCCDDEEFF / DEFAULT_DEST_MAC, 48'h001122334455 / DEFAULT_ETHER_TYPE, 16'h0800: shadow reset values
- sys_clk  in  1  clock, 156.25 MHz
- sys_rst_n  in  1  reset, asynchronous, active-low
- ch_soft_rst  in  NUM_CH  per-channel software reset request, level
- rx_block_lock  in  NUM_CH  PCS block-lock per channel
- tx_frame_valid, tx_frame_error, rx_frame_valid, rx_frame_error, rx_crc_error  in  NUM_CH each  single-cycle event pulses from each MAC
- config_valid  in  1  configuration write strobe
- config_ch  in  CH_W  target channel
- config_local_mac / config_dest_mac  in  48  new MAC addresses
- config_ether_type  in  16  new EtherType
- config_promiscuous  in  1  new promiscuous flag
- ch_rst  out  NUM_CH  per-channel core reset
- ch_local_mac / ch_dest_mac  out  48*NUM_CH  shadow addresses, channel i at [48i+47:48i]
- ch_ether_type  out  16*NUM_CH  shadow EtherType
- ch_promiscuous  out  NUM_CH  shadow promiscuous flag
- link_up  out  NUM_CH  debounced link state
- link_speed  out  4*NUM_CH  4'h1 = 10G while link up, else 4'h0
- stat_rd_en  in  1  read request pulse
- stat_rd_ch  in  CH_W  channel to read
- stat_rd_sel  in  3  counter select: 0 tx_ok, 1 tx_err, 2 rx_ok, 3 rx_err, 4 rx_crc
- stat_rd_clr  in  1  clear the selected counter on read
- stat_rd_data  out  STAT_WIDTH  read data
- stat_rd_valid  out  1  read data valid

## Operation
- Per-channel FSM: S_RST -> S_DOWN -> S_UP.
- S_RST: ch_rst active, stretch counter counts RST_STRETCH cycles, then S_DOWN.
- S_DOWN: debounce counter increments while rx_block_lock is high and clears on any low cycle. On reaching LINK_UP_CYCLES, go to S_UP.
- S_UP: link_up=1, link_speed=4'h1. rx_block_lock low for one cycle -> S_DOWN immediately, no debounce on loss.
- ch_soft_rst high in any state -> S_RST with the stretch counter reloaded. While held high, the channel stays in S_RST. Stretch counts from the release edge.
- Config: config_valid with config_ch < NUM_CH writes all four shadow fields of that channel in one cycle. config_ch >= NUM_CH is ignored. Shadows survive soft reset.
- Stats: 5 counters per channel, each saturating at all-ones.
  - Events are ignored while the channel is in S_RST.
  - Soft reset does not clear counters.
- Read-with-clear: the counter returns its current value and is set to 0. An event in the same cycle makes the post-clear value 1, so no event is lost.
- Reads with out-of-range ch or sel return 0 with stat_rd_valid still asserted, and clear nothing.

## Timing
- Reset values:
  - ch_rst active, link_up 0, link_speed 0, all counters 0.
  - Shadows at their defaults; stat_rd_valid 0, stat_rd_data 0.
- After sys_rst_n deasserts, ch_rst releases on the RST_STRETCH-th rising edge with sys_rst_n high.
- ch_soft_rst sampled high at edge N: ch_rst is active after N. Release RST_STRETCH edges after the first edge with ch_soft_rst low.
- rx_block_lock high from edge M, continuously: link_up rises after edge M+LINK_UP_CYCLES.
- Loss of lock: lock low at edge K -> link_up low after K.
- Config write at edge N: outputs show the new value after N.
- stat_rd_en at edge N: stat_rd_data/stat_rd_valid are registered and valid for exactly one cycle after N. Back-to-back reads are supported every cycle.
- The data returned is the pre-increment value at edge N.

## Structure
- Package eth_ctrl_pkg:
  - FSM state encoding (S_RST, S_DOWN, S_UP).
  - stat_rd_sel codes and the link-speed code SPEED_10G = 4'h1.
- Sub-module eth_ch_ctrl per channel (generate loop): FSM, stretch/debounce counters, shadows, five counters.
- The top handles config decode and the registered stat read mux.

## Test plan
- Power-on, RST_STRETCH=16: ch_rst active for 16 edges after sys_rst_n release, then inactive; shadows equal defaults; link_up=0.
- Lock debounce, LINK_UP_CYCLES=8:
  - Lock high 7 cycles, low 1, high 8: link_up rises only after the second run, with link_speed=4'h1.
  - Lock drop gives link_up=0 the next cycle.
- Soft reset ch1 while up: ch1 ch_rst active and link_up=0; ch0 is unaffected; ch1 counters are preserved.
- Config: write ch1 dest_mac=48'h0A0B0C0D0E0F then config_ch=NUM_CH. ch1 updates in 1 cycle; the out-of-range write changes nothing.
- Stats, STAT_WIDTH=4:
  - 20 rx_ok pulses read back 4'hF (saturation).
  - Read-with-clear coincident with a pulse returns 4'hF; the next read returns 1.
- Invalid read: sel=7 returns 0 with stat_rd_valid=1; no counter changes.
